// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
// Follows the PS/2 Set-2 byte stream and tracks the held/released state of
// one key. The key is selected by KEY_CODE/KEY_EXT. E0 (extended) and F0
// (break) prefixes are decoded. Typematic repeats are absorbed, so rise
// fires once per physical press.
//
// Optional build macro: KEY_TIMEOUT_EN
//   When defined, a pending prefix is abandoned after TIMEOUT_CYCLES quiet
//   cycles. When undefined, a pending prefix waits indefinitely for the
//   next byte, and TIMEOUT_CYCLES is ignored.
//
// Handshake: code_byte is sampled only on cycles where code_valid=1. There
// is no backpressure; every strobed byte is consumed on that edge unless
// flush is high on the same cycle, in which case the byte is dropped.
//
// Outputs pressed/rise/fall are all registered. They change on the edge
// that samples the completing byte (or flush), so they become visible in
// the following cycle.
module ps2_key_tracker #(
    parameter logic [7:0]  KEY_CODE       = 8'h29,
    parameter logic        KEY_EXT        = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] code_byte,
    input  logic       code_valid,
    input  logic       flush,
    output logic       pressed,
    output logic       rise,
    output logic       fall
);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t state;

    logic is_ext;
    logic is_brk;
    logic plain_hit;
    logic ext_hit;
    logic timeout_hit;

    // Classify the incoming byte. A key hit is qualified by the key's
    // extended flag, so an extended code never matches a plain key and
    // a plain code never matches an extended key.
    always_comb begin
        is_ext    = (code_byte == BYTE_EXT);
        is_brk    = (code_byte == BYTE_BRK);
        plain_hit = (code_byte == KEY_CODE) && !KEY_EXT;
        ext_hit   = (code_byte == KEY_CODE) && KEY_EXT;
    end

`ifdef KEY_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] quiet_cnt;

    // Count quiet cycles while a prefix is pending. Any byte, IDLE,
    // flush or an expiry restarts the count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            quiet_cnt <= '0;
        end else if (flush || code_valid || (state == IDLE) || timeout_hit) begin
            quiet_cnt <= '0;
        end else begin
            quiet_cnt <= quiet_cnt + CNT_W'(1);
        end
    end

    // Expiry applies only on cycles with no byte; a byte arriving on the
    // expiry cycle is decoded normally instead.
    always_comb begin
        timeout_hit = (state != IDLE) && !code_valid && (quiet_cnt == CNT_LAST);
    end
`else
    // Without the timeout option, a pending prefix never expires.
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // Prefix decoder plus make/break handling. Pulses default low every
    // cycle, so each one lasts exactly one cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            pressed <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (flush) begin
                // Flush drops any byte on this cycle and releases the key.
                state   <= IDLE;
                pressed <= 1'b0;
                fall    <= pressed;
            end else if (code_valid) begin
                unique case (state)
                    IDLE: begin
                        if (is_ext) begin
                            state <= EXT;
                        end else if (is_brk) begin
                            state <= BRK;
                        end else begin
                            state <= IDLE;
                            if (plain_hit) begin
                                pressed <= 1'b1;
                                rise    <= !pressed;
                            end
                        end
                    end
                    EXT: begin
                        if (is_brk) begin
                            state <= EXT_BRK;
                        end else if (is_ext) begin
                            state <= EXT;
                        end else begin
                            state <= IDLE;
                            if (ext_hit) begin
                                pressed <= 1'b1;
                                rise    <= !pressed;
                            end
                        end
                    end
                    BRK: begin
                        // A fresh E0 after F0 means the stream resynced;
                        // it starts a new extended sequence.
                        if (is_ext) begin
                            state <= EXT;
                        end else if (is_brk) begin
                            state <= BRK;
                        end else begin
                            state <= IDLE;
                            if (plain_hit) begin
                                pressed <= 1'b0;
                                fall    <= pressed;
                            end
                        end
                    end
                    EXT_BRK: begin
                        if (is_ext) begin
                            state <= EXT;
                        end else if (is_brk) begin
                            state <= EXT_BRK;
                        end else begin
                            state <= IDLE;
                            if (ext_hit) begin
                                pressed <= 1'b0;
                                fall    <= pressed;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (timeout_hit) begin
                // Abandoned prefix: back to IDLE, key state untouched.
                state <= IDLE;
            end
        end
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Tracks the press/release state of one configurable PS/2 Set-2 key from the received byte stream.
- Sits between the PS/2 byte receiver (upstream, supplies `code_byte` and `code_valid`) and the per-key release detectors (downstream, consume `pressed` and `rise`).
- Decodes the E0 (extended) and F0 (break) prefixes. Typematic repeats are suppressed, so `rise` fires once per physical press.

Parameters:
- KEY_CODE, 8'h29, scan code of the tracked key (default: space).
- KEY_EXT, 1'b0, 1 = key is an E0-extended key (e.g. arrows), 0 = plain key.
- TIMEOUT_CYCLES, 1_000_000, prefix-abandon timeout in clk cycles. Used only with KEY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- code_byte  in  8  received PS/2 byte; valid only while code_valid=1.
- code_valid  in  1  one-cycle strobe per received byte.
- flush  in  1  synchronous clear of FSM and key state.
- pressed  out  1  level: key is currently held.
- rise  out  1  one-cycle pulse when pressed goes 0->1.
- fall  out  1  one-cycle pulse when pressed goes 1->0.

Behaviour:
- Reset and clocking:
  - Reset is asynchronous and active-low (resetN); clock is clk.
  - Reset state: FSM in IDLE, pressed=0, rise=0, fall=0.
- FSM states:
  - IDLE: no prefix pending.
  - EXT: E0 received.
  - BRK: F0 received.
  - EXT_BRK: E0 then F0 received.
- Bytes are evaluated only on cycles where code_valid=1. With code_valid=0 the FSM holds (except for the timeout option).
- Transitions:
  - IDLE: E0 -> EXT; F0 -> BRK; byte==KEY_CODE with KEY_EXT=0 -> make event, stay IDLE; any other byte -> IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; byte==KEY_CODE with KEY_EXT=1 -> make event, then IDLE; other -> IDLE.
  - BRK: byte==KEY_CODE with KEY_EXT=0 -> break event, then IDLE; E0 -> EXT (resync); F0 -> BRK; other -> IDLE.
  - EXT_BRK: byte==KEY_CODE with KEY_EXT=1 -> break event, then IDLE; E0 -> EXT; F0 -> EXT_BRK; other -> IDLE.
- Extended/plain matching:
  - An extended code never matches a plain key and vice versa. E.g. E0 29 with KEY_EXT=0 produces no event.
- Events:
  - make: pressed<=1. rise<=1 only if pressed was 0.
  - break: pressed<=0. fall<=1 only if pressed was 1.
- Typematic and spurious codes:
  - Repeated makes while pressed=1 produce no rise.
  - A break while pressed=0 produces no fall.
  - Non-key bytes (AA, FA, FE, EE) are ordinary non-matching bytes.
- Latency:
  - pressed, rise and fall update on the clock edge that samples the completing code_valid.
  - They are visible the cycle after the strobe.
  - rise and fall are high for exactly one cycle, then return to 0.
- flush:
  - Synchronous clear: FSM->IDLE, pressed<=0, fall<=1 if pressed was 1, rise<=0.
  - flush wins over a simultaneous code_valid (the byte is dropped).
- Reset mid-sequence (e.g. after F0): returns to IDLE. The next matching byte is then interpreted as a make.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: KEY_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES) bits clears on every code_valid and in IDLE, and increments while in EXT, BRK or EXT_BRK.
  - On reaching TIMEOUT_CYCLES-1 without a new byte, the FSM returns to IDLE. pressed is unchanged and no pulse is generated.
  - A code_valid on the same cycle as expiry takes priority: the byte is evaluated normally.
- Not defined:
  - No counter logic; prefix states persist indefinitely until the next byte.

Test Plan:
- Plain press/release: with defaults, send 29 then F0 29 -> rise pulse 1 cycle after the 29 strobe, pressed=1; fall pulse and pressed=0 after the second 29.
- Typematic: send 29 ×5 -> exactly one rise, pressed stays 1, no fall; then F0 29 -> single fall.
- Extended filtering: KEY_EXT=0, send E0 29 and E0 F0 29 -> no rise/fall. With KEY_EXT=1, KEY_CODE=8'h75, send E0 75 then E0 F0 75 -> rise then fall.
- Spurious break and resync: send F0 29 while released -> no fall. Send F0 E0 29 with KEY_EXT=0 -> no event, FSM ends in IDLE.
- flush/reset: press 29, assert flush together with code_valid=F0 -> pressed=0 and one fall pulse. Assert resetN=0 after F0, release reset, send 29 -> rise.
- Timeout (KEY_TIMEOUT_EN, TIMEOUT_CYCLES=16): press 29, send F0, idle 20 cycles, send 29 -> pressed stays 1, no fall, no rise.
